// File: rtl/borb_bus_pkg.sv
// Shared types for the iBus/dBus memory arbiter: request source, tag layout and
// default bus widths.
package borb_bus_pkg;

  localparam int ADDR_W_DEF    = 64;
  localparam int DATA_W_DEF    = 64;
  localparam int ID_W_DEF      = 16;
  localparam int MAX_OUTST_DEF = 4;

  typedef enum logic {
    IBUS = 1'b0,
    DBUS = 1'b1
  } src_e;

  typedef struct packed {
    src_e                  src;
    logic [ADDR_W_DEF-1:0] address;
    logic [ID_W_DEF-1:0]   id;
  } tag_t;

  function automatic src_e other_src(input src_e s);
    return (s == IBUS) ? DBUS : IBUS;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU iBus/dBus ports, the arbiter and the memory.
// slave = arbiter view, master = surrounding core + memory view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 16
);
  // Commands use valid/ready: a transfer happens on a cycle where both are 1;
  // the requester holds valid and payload stable until then. Responses are
  // single-cycle valid strobes with no backpressure.
  logic                io_iBus_cmd_valid;
  logic                io_iBus_cmd_ready;
  logic [ADDR_W-1:0]   io_iBus_cmd_payload_address;
  logic [ID_W-1:0]     io_iBus_cmd_payload_id;
  logic                io_iBus_rsp_valid;
  logic [DATA_W-1:0]   io_iBus_rsp_payload_data;
  logic [ADDR_W-1:0]   io_iBus_rsp_payload_address;
  logic [ID_W-1:0]     io_iBus_rsp_payload_id;

  logic                io_dBus_cmd_valid;
  logic                io_dBus_cmd_ready;
  logic [ADDR_W-1:0]   io_dBus_cmd_payload_address;
  logic [DATA_W-1:0]   io_dBus_cmd_payload_data;
  logic [DATA_W/8-1:0] io_dBus_cmd_payload_mask;
  logic                io_dBus_cmd_payload_write;
  logic                io_dBus_rsp_valid;
  logic [DATA_W-1:0]   io_dBus_rsp_payload_data;

  logic                io_mem_cmd_valid;
  logic                io_mem_cmd_ready;
  logic [ADDR_W-1:0]   io_mem_cmd_payload_address;
  logic [DATA_W-1:0]   io_mem_cmd_payload_data;
  logic [DATA_W/8-1:0] io_mem_cmd_payload_mask;
  logic                io_mem_cmd_payload_write;
  logic                io_mem_rsp_valid;
  logic [DATA_W-1:0]   io_mem_rsp_payload_data;

  modport slave (
    input  io_iBus_cmd_valid, io_iBus_cmd_payload_address, io_iBus_cmd_payload_id,
    output io_iBus_cmd_ready, io_iBus_rsp_valid, io_iBus_rsp_payload_data,
    output io_iBus_rsp_payload_address, io_iBus_rsp_payload_id,
    input  io_dBus_cmd_valid, io_dBus_cmd_payload_address, io_dBus_cmd_payload_data,
    input  io_dBus_cmd_payload_mask, io_dBus_cmd_payload_write,
    output io_dBus_cmd_ready, io_dBus_rsp_valid, io_dBus_rsp_payload_data,
    output io_mem_cmd_valid, io_mem_cmd_payload_address, io_mem_cmd_payload_data,
    output io_mem_cmd_payload_mask, io_mem_cmd_payload_write,
    input  io_mem_cmd_ready, io_mem_rsp_valid, io_mem_rsp_payload_data
  );

  modport master (
    output io_iBus_cmd_valid, io_iBus_cmd_payload_address, io_iBus_cmd_payload_id,
    input  io_iBus_cmd_ready, io_iBus_rsp_valid, io_iBus_rsp_payload_data,
    input  io_iBus_rsp_payload_address, io_iBus_rsp_payload_id,
    output io_dBus_cmd_valid, io_dBus_cmd_payload_address, io_dBus_cmd_payload_data,
    output io_dBus_cmd_payload_mask, io_dBus_cmd_payload_write,
    input  io_dBus_cmd_ready, io_dBus_rsp_valid, io_dBus_rsp_payload_data,
    input  io_mem_cmd_valid, io_mem_cmd_payload_address, io_mem_cmd_payload_data,
    input  io_mem_cmd_payload_mask, io_mem_cmd_payload_write,
    output io_mem_cmd_ready, io_mem_rsp_valid, io_mem_rsp_payload_data
  );

endinterface

// File: rtl/mem_bus_arbiter_tag_fifo.sv
// In-order tag FIFO recording who issued each outstanding memory read.
// Storage is write-only-on-push with no reset; pointers and count reset async.
module arb_tag_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // Full blocks a push even if a pop frees a slot in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between iBus and dBus, with an
// in-order tag FIFO steering registered read responses back to their issuer.
module mem_bus_arbiter
  import borb_bus_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ID_W      = ID_W_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic               io_clk,
  input  logic               io_reset,
  mem_bus_arbiter_if.slave   bus,
  output logic               io_err_spurious
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_OUTST) + 1;

  typedef struct packed {
    src_e              src;
    logic [ADDR_W-1:0] address;
    logic [ID_W-1:0]   id;
  } arb_tag_t;

  localparam int TAG_W = $bits(arb_tag_t);

  src_e       last_grant;
  logic       locked;
  src_e       locked_src;
  logic       i_elig;
  logic       d_elig;
  logic       have_win;
  src_e       win_src;
  logic       handshake;
  logic       push;
  arb_tag_t   push_tag;
  arb_tag_t   head_tag;
  logic       fifo_full;
  logic       fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic       rsp_fire;

  logic              irsp_valid;
  logic [DATA_W-1:0] irsp_data;
  logic [ADDR_W-1:0] irsp_addr;
  logic [ID_W-1:0]   irsp_id;
  logic              drsp_valid;
  logic [DATA_W-1:0] drsp_data;

  // A stalled winner keeps the grant (locked) so its payload cannot be swapped
  // out from under the memory before it accepts.
  always_comb begin
    i_elig   = bus.io_iBus_cmd_valid & ~fifo_full;
    d_elig   = bus.io_dBus_cmd_valid & (bus.io_dBus_cmd_payload_write | ~fifo_full);
    have_win = i_elig | d_elig;
    win_src  = IBUS;
    if (locked && ((locked_src == IBUS) ? i_elig : d_elig)) win_src = locked_src;
    else if (i_elig && d_elig)                              win_src = other_src(last_grant);
    else if (d_elig)                                        win_src = DBUS;
  end

  always_comb begin
    bus.io_mem_cmd_valid           = have_win;
    bus.io_mem_cmd_payload_address = '0;
    bus.io_mem_cmd_payload_data    = '0;
    bus.io_mem_cmd_payload_mask    = '0;
    bus.io_mem_cmd_payload_write   = 1'b0;
    bus.io_iBus_cmd_ready          = 1'b0;
    bus.io_dBus_cmd_ready          = 1'b0;
    if (have_win && win_src == IBUS) begin
      bus.io_mem_cmd_payload_address = bus.io_iBus_cmd_payload_address;
      bus.io_mem_cmd_payload_mask    = {MASK_W{1'b1}};
      bus.io_iBus_cmd_ready          = bus.io_mem_cmd_ready;
    end else if (have_win) begin
      bus.io_mem_cmd_payload_address = bus.io_dBus_cmd_payload_address;
      bus.io_mem_cmd_payload_data    = bus.io_dBus_cmd_payload_data;
      bus.io_mem_cmd_payload_mask    = bus.io_dBus_cmd_payload_mask;
      bus.io_mem_cmd_payload_write   = bus.io_dBus_cmd_payload_write;
      bus.io_dBus_cmd_ready          = bus.io_mem_cmd_ready;
    end
  end

  assign handshake = have_win & bus.io_mem_cmd_ready;
  assign push      = handshake & ~((win_src == DBUS) & bus.io_dBus_cmd_payload_write);

  always_comb begin
    push_tag = '0;
    push_tag.src = win_src;
    if (win_src == IBUS) begin
      push_tag.address = bus.io_iBus_cmd_payload_address;
      push_tag.id      = bus.io_iBus_cmd_payload_id;
    end
  end

  arb_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk   (io_clk),
    .rst_n (io_reset),
    .push  (push),
    .din   (push_tag),
    .pop   (rsp_fire),
    .dout  (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rsp_fire = bus.io_mem_rsp_valid & ~fifo_empty;

  always_ff @(posedge io_clk or negedge io_reset) begin
    if (!io_reset) begin
      last_grant <= DBUS;
      locked     <= 1'b0;
      locked_src <= IBUS;
    end else begin
      if (handshake) last_grant <= win_src;
      locked     <= have_win & ~bus.io_mem_cmd_ready;
      locked_src <= win_src;
    end
  end

  always_ff @(posedge io_clk or negedge io_reset) begin
    if (!io_reset) begin
      irsp_valid      <= 1'b0;
      irsp_data       <= '0;
      irsp_addr       <= '0;
      irsp_id         <= '0;
      drsp_valid      <= 1'b0;
      drsp_data       <= '0;
      io_err_spurious <= 1'b0;
    end else begin
      irsp_valid <= rsp_fire & (head_tag.src == IBUS);
      drsp_valid <= rsp_fire & (head_tag.src == DBUS);
      if (rsp_fire && head_tag.src == IBUS) begin
        irsp_data <= bus.io_mem_rsp_payload_data;
        irsp_addr <= head_tag.address;
        irsp_id   <= head_tag.id;
      end
      if (rsp_fire && head_tag.src == DBUS) drsp_data <= bus.io_mem_rsp_payload_data;
      // A response with nothing outstanding is dropped and flagged until reset.
      if (bus.io_mem_rsp_valid && fifo_count == '0) io_err_spurious <= 1'b1;
    end
  end

  assign bus.io_iBus_rsp_valid           = irsp_valid;
  assign bus.io_iBus_rsp_payload_data    = irsp_data;
  assign bus.io_iBus_rsp_payload_address = irsp_addr;
  assign bus.io_iBus_rsp_payload_id      = irsp_id;
  assign bus.io_dBus_rsp_valid           = drsp_valid;
  assign bus.io_dBus_rsp_payload_data    = drsp_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: command grants checked inline, read
// responses checked by a scoreboard fed from the bench's own issue record.
module tb_mem_bus_arbiter;

  logic io_clk = 1'b0;
  logic io_reset;
  logic err;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    logic        is_i;
    logic [63:0] addr;
    logic [15:0] id;
  } rd_t;

  typedef struct {
    logic        is_i;
    logic [63:0] data;
    logic [63:0] addr;
    logic [15:0] id;
    int          due;
  } exp_t;

  rd_t  rd_q[$];
  exp_t exp_q[$];

  mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64), .ID_W(16)) bus ();

  mem_bus_arbiter #(
    .ADDR_W(64), .DATA_W(64), .ID_W(16), .MAX_OUTST(4)
  ) dut (
    .io_clk          (io_clk),
    .io_reset        (io_reset),
    .bus             (bus),
    .io_err_spurious (err)
  );

  always #5 io_clk = ~io_clk;
  always @(posedge io_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic drive_i(input logic v, input logic [63:0] a, input logic [15:0] id);
    bus.io_iBus_cmd_valid           = v;
    bus.io_iBus_cmd_payload_address = a;
    bus.io_iBus_cmd_payload_id      = id;
  endtask

  task automatic drive_d(input logic v, input logic wr, input logic [63:0] a,
                         input logic [63:0] d, input logic [7:0] m);
    bus.io_dBus_cmd_valid           = v;
    bus.io_dBus_cmd_payload_write   = wr;
    bus.io_dBus_cmd_payload_address = a;
    bus.io_dBus_cmd_payload_data    = d;
    bus.io_dBus_cmd_payload_mask    = m;
  endtask

  // Drive a memory response for the oldest read the bench issued and queue
  // what the requester must see one cycle later.
  task automatic set_rsp(input logic [63:0] d);
    rd_t  r;
    exp_t e;
    r = rd_q.pop_front();
    bus.io_mem_rsp_valid        = 1'b1;
    bus.io_mem_rsp_payload_data = d;
    e.is_i = r.is_i;
    e.data = d;
    e.addr = r.addr;
    e.id   = r.id;
    e.due  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic rsp_off();
    bus.io_mem_rsp_valid        = 1'b0;
    bus.io_mem_rsp_payload_data = '0;
  endtask

  task automatic push_rd(input logic is_i, input logic [63:0] a, input logic [15:0] id);
    rd_t r;
    r.is_i = is_i;
    r.addr = a;
    r.id   = id;
    rd_q.push_back(r);
  endtask

  always @(negedge io_clk) begin
    exp_t e;
    if (bus.io_iBus_rsp_valid === 1'b1 || bus.io_dBus_rsp_valid === 1'b1) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_rsp: observed i=%b d=%b expected no response",
               bus.io_iBus_rsp_valid, bus.io_dBus_rsp_valid);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(e.due));
        chk("rsp_ibus_valid", bus.io_iBus_rsp_valid, e.is_i);
        chk("rsp_dbus_valid", bus.io_dBus_rsp_valid, !e.is_i);
        if (e.is_i) begin
          chk("ibus_rsp_data", bus.io_iBus_rsp_payload_data, e.data);
          chk("ibus_rsp_addr", bus.io_iBus_rsp_payload_address, e.addr);
          chk("ibus_rsp_id", bus.io_iBus_rsp_payload_id, e.id);
        end else begin
          chk("dbus_rsp_data", bus.io_dBus_rsp_payload_data, e.data);
        end
      end
    end
  end

  initial begin
    logic [63:0] ia, da, ea;
    io_reset = 1'b0;
    drive_i(1'b0, '0, '0);
    drive_d(1'b0, 1'b0, '0, '0, '0);
    bus.io_mem_cmd_ready = 1'b0;
    rsp_off();

    // Reset state
    repeat (2) @(posedge io_clk);
    #1;
    chk("reset_ibus_rsp_valid", bus.io_iBus_rsp_valid, 1'b0);
    chk("reset_dbus_rsp_valid", bus.io_dBus_rsp_valid, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_ibus_rsp_data", bus.io_iBus_rsp_payload_data, 64'h0);
    chk("reset_mem_cmd_valid", bus.io_mem_cmd_valid, 1'b0);
    io_reset = 1'b1;

    // Basic iBus read
    tick();
    drive_i(1'b1, 64'h1000, 16'd5);
    bus.io_mem_cmd_ready = 1'b1;
    @(negedge io_clk);
    chk("basic_cmd_valid", bus.io_mem_cmd_valid, 1'b1);
    chk("basic_cmd_addr", bus.io_mem_cmd_payload_address, 64'h1000);
    chk("basic_cmd_write", bus.io_mem_cmd_payload_write, 1'b0);
    chk("basic_cmd_mask", bus.io_mem_cmd_payload_mask, 8'hFF);
    chk("basic_cmd_data", bus.io_mem_cmd_payload_data, 64'h0);
    chk("basic_ibus_ready", bus.io_iBus_cmd_ready, 1'b1);
    chk("basic_dbus_ready", bus.io_dBus_cmd_ready, 1'b0);
    push_rd(1'b1, 64'h1000, 16'd5);
    tick();
    drive_i(1'b0, '0, '0);
    tick();
    set_rsp(64'hDEAD);
    tick();
    rsp_off();
    tick();

    // Lone dBus write: no response, and leaves last grant on dBus
    drive_d(1'b1, 1'b1, 64'h2000, 64'h55, 8'h0F);
    @(negedge io_clk);
    chk("wr_cmd_write", bus.io_mem_cmd_payload_write, 1'b1);
    chk("wr_cmd_mask", bus.io_mem_cmd_payload_mask, 8'h0F);
    chk("wr_cmd_data", bus.io_mem_cmd_payload_data, 64'h55);
    chk("wr_cmd_addr", bus.io_mem_cmd_payload_address, 64'h2000);
    chk("wr_dbus_ready", bus.io_dBus_cmd_ready, 1'b1);
    chk("wr_ibus_ready", bus.io_iBus_cmd_ready, 1'b0);
    tick();
    drive_d(1'b0, 1'b0, '0, '0, '0);

    // Round-robin contention with continuous responses: I, D, I, D
    for (int k = 0; k < 4; k++) begin
      ia = 64'h3000 + 64'(8 * ((k + 1) / 2));
      da = 64'h4000 + 64'(8 * (k / 2));
      drive_i(1'b1, ia, 16'(10 + (k + 1) / 2));
      drive_d(1'b1, 1'b0, da, '0, '0);
      if (k > 0) set_rsp(64'hA0 + 64'(k));
      @(negedge io_clk);
      ea = (k % 2 == 0) ? ia : da;
      chk("rr_ibus_ready", bus.io_iBus_cmd_ready, (k % 2 == 0));
      chk("rr_dbus_ready", bus.io_dBus_cmd_ready, (k % 2 == 1));
      chk("rr_cmd_addr", bus.io_mem_cmd_payload_address, ea);
      if (k % 2 == 0) push_rd(1'b1, ia, 16'(10 + k / 2));
      else            push_rd(1'b0, '0, '0);
      tick();
    end
    drive_i(1'b0, '0, '0);
    drive_d(1'b0, 1'b0, '0, '0, '0);
    set_rsp(64'hA4);
    tick();
    rsp_off();

    // Stall: dBus wins alone, iBus arrives mid-stall; grant must stay on dBus
    bus.io_mem_cmd_ready = 1'b0;
    drive_d(1'b1, 1'b0, 64'h6000, '0, '0);
    @(negedge io_clk);
    chk("stall_cmd_valid", bus.io_mem_cmd_valid, 1'b1);
    chk("stall_cmd_addr", bus.io_mem_cmd_payload_address, 64'h6000);
    chk("stall_dbus_ready", bus.io_dBus_cmd_ready, 1'b0);
    for (int s = 1; s < 3; s++) begin
      tick();
      drive_i(1'b1, 64'h5000, 16'd20);
      @(negedge io_clk);
      chk("stall_hold_addr", bus.io_mem_cmd_payload_address, 64'h6000);
      chk("stall_hold_valid", bus.io_mem_cmd_valid, 1'b1);
      chk("stall_hold_ibus_ready", bus.io_iBus_cmd_ready, 1'b0);
      chk("stall_hold_dbus_ready", bus.io_dBus_cmd_ready, 1'b0);
    end
    tick();
    bus.io_mem_cmd_ready = 1'b1;
    @(negedge io_clk);
    chk("stall_rel_dbus_ready", bus.io_dBus_cmd_ready, 1'b1);
    chk("stall_rel_ibus_ready", bus.io_iBus_cmd_ready, 1'b0);
    chk("stall_rel_addr", bus.io_mem_cmd_payload_address, 64'h6000);
    push_rd(1'b0, '0, '0);
    tick();
    drive_d(1'b0, 1'b0, '0, '0, '0);
    @(negedge io_clk);
    chk("stall_next_ibus_ready", bus.io_iBus_cmd_ready, 1'b1);
    chk("stall_next_addr", bus.io_mem_cmd_payload_address, 64'h5000);
    push_rd(1'b1, 64'h5000, 16'd20);
    tick();
    drive_i(1'b0, '0, '0);
    set_rsp(64'hB1);
    tick();
    set_rsp(64'hB2);
    tick();
    rsp_off();

    // Full FIFO: four reads outstanding, a fifth read blocks, a write passes
    for (int j = 0; j < 4; j++) begin
      drive_i(1'b1, 64'h7000 + 64'(8 * j), 16'(30 + j));
      @(negedge io_clk);
      chk("fill_ibus_ready", bus.io_iBus_cmd_ready, 1'b1);
      push_rd(1'b1, 64'h7000 + 64'(8 * j), 16'(30 + j));
      tick();
    end
    drive_i(1'b1, 64'h7020, 16'd34);
    drive_d(1'b1, 1'b1, 64'h8000, 64'h1234, 8'h0F);
    @(negedge io_clk);
    chk("full_ibus_ready", bus.io_iBus_cmd_ready, 1'b0);
    chk("full_dbus_ready", bus.io_dBus_cmd_ready, 1'b1);
    chk("full_cmd_addr", bus.io_mem_cmd_payload_address, 64'h8000);
    chk("full_cmd_write", bus.io_mem_cmd_payload_write, 1'b1);
    chk("full_cmd_mask", bus.io_mem_cmd_payload_mask, 8'h0F);
    chk("full_cmd_data", bus.io_mem_cmd_payload_data, 64'h1234);
    tick();
    drive_d(1'b0, 1'b0, '0, '0, '0);
    set_rsp(64'hC0);
    @(negedge io_clk);
    chk("full_pop_ibus_ready", bus.io_iBus_cmd_ready, 1'b0);
    chk("full_pop_cmd_valid", bus.io_mem_cmd_valid, 1'b0);
    tick();
    rsp_off();
    @(negedge io_clk);
    chk("unfull_ibus_ready", bus.io_iBus_cmd_ready, 1'b1);
    chk("unfull_cmd_addr", bus.io_mem_cmd_payload_address, 64'h7020);
    push_rd(1'b1, 64'h7020, 16'd34);
    tick();
    drive_i(1'b0, '0, '0);
    for (int n = 0; n < 4; n++) begin
      set_rsp(64'hC1 + 64'(n));
      tick();
    end
    rsp_off();

    // In-order routing: I(id 1), D, I(id 2)
    drive_i(1'b1, 64'h9000, 16'd1);
    @(negedge io_clk);
    chk("ord_i1_ready", bus.io_iBus_cmd_ready, 1'b1);
    push_rd(1'b1, 64'h9000, 16'd1);
    tick();
    drive_i(1'b0, '0, '0);
    drive_d(1'b1, 1'b0, 64'h9100, '0, '0);
    @(negedge io_clk);
    chk("ord_d_ready", bus.io_dBus_cmd_ready, 1'b1);
    push_rd(1'b0, '0, '0);
    tick();
    drive_d(1'b0, 1'b0, '0, '0, '0);
    drive_i(1'b1, 64'h9200, 16'd2);
    @(negedge io_clk);
    chk("ord_i2_ready", bus.io_iBus_cmd_ready, 1'b1);
    push_rd(1'b1, 64'h9200, 16'd2);
    tick();
    drive_i(1'b0, '0, '0);
    set_rsp(64'hAAAA);
    tick();
    set_rsp(64'hBBBB);
    tick();
    set_rsp(64'hCCCC);
    tick();
    rsp_off();
    tick();

    // Spurious response with nothing outstanding
    @(negedge io_clk);
    chk("pre_spur_err", err, 1'b0);
    tick();
    bus.io_mem_rsp_valid        = 1'b1;
    bus.io_mem_rsp_payload_data = 64'h5151;
    tick();
    rsp_off();
    @(negedge io_clk);
    chk("spur_err", err, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge io_clk);
      chk("spur_err_held", err, 1'b1);
    end

    // Reset mid-operation: two reads outstanding, a response pulse in flight
    tick();
    drive_i(1'b1, 64'hA000, 16'd40);
    @(negedge io_clk);
    chk("rst_i_ready", bus.io_iBus_cmd_ready, 1'b1);
    tick();
    drive_i(1'b0, '0, '0);
    drive_d(1'b1, 1'b0, 64'hA100, '0, '0);
    @(negedge io_clk);
    chk("rst_d_ready", bus.io_dBus_cmd_ready, 1'b1);
    tick();
    drive_d(1'b0, 1'b0, '0, '0, '0);
    bus.io_mem_rsp_valid        = 1'b1;
    bus.io_mem_rsp_payload_data = 64'h7777;
    @(posedge io_clk);
    #2;
    chk("rst_pending_pulse", bus.io_iBus_rsp_valid, 1'b1);
    io_reset = 1'b0;
    rsp_off();
    #1;
    chk("rst_async_ibus_valid", bus.io_iBus_rsp_valid, 1'b0);
    chk("rst_async_dbus_valid", bus.io_dBus_rsp_valid, 1'b0);
    chk("rst_async_err", err, 1'b0);
    chk("rst_async_ibus_data", bus.io_iBus_rsp_payload_data, 64'h0);
    chk("rst_async_ibus_addr", bus.io_iBus_rsp_payload_address, 64'h0);
    chk("rst_async_ibus_id", bus.io_iBus_rsp_payload_id, 16'h0);
    chk("rst_async_cmd_valid", bus.io_mem_cmd_valid, 1'b0);
    chk("rst_async_ibus_ready", bus.io_iBus_cmd_ready, 1'b0);
    chk("rst_async_dbus_ready", bus.io_dBus_cmd_ready, 1'b0);
    rd_q.delete();
    repeat (2) @(posedge io_clk);
    #1;
    io_reset = 1'b1;
    bus.io_mem_rsp_valid        = 1'b1;
    bus.io_mem_rsp_payload_data = 64'h8888;
    tick();
    rsp_off();
    drive_i(1'b1, 64'hB000, 16'd50);
    drive_d(1'b1, 1'b0, 64'hB100, '0, '0);
    @(negedge io_clk);
    chk("post_rst_spur_err", err, 1'b1);
    chk("post_rst_ibus_ready", bus.io_iBus_cmd_ready, 1'b1);
    chk("post_rst_dbus_ready", bus.io_dBus_cmd_ready, 1'b0);
    chk("post_rst_cmd_addr", bus.io_mem_cmd_payload_address, 64'hB000);
    push_rd(1'b1, 64'hB000, 16'd50);
    tick();
    drive_i(1'b0, '0, '0);
    drive_d(1'b0, 1'b0, '0, '0, '0);
    set_rsp(64'hEE);
    tick();
    rsp_off();
    repeat (2) tick();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one memory port between the CPU instruction bus (iBus) and data bus (dBus).
- Arbitrates command issue round-robin.
- Tracks outstanding reads in an in-order tag FIFO.
- Routes each memory read response back to the requester that issued it, with a registered one-cycle response path.
- Sits between the CPU core's io_iBus_*/io_dBus_* ports and the single external/simulation memory.

Parameters:
ADDR_W, 64, address width of all buses
DATA_W, 64, data width of all buses
ID_W, 16, iBus transaction id width
MAX_OUTST, 4, outstanding-read capacity (tag FIFO depth, power of two)

Ports:
io_clk  in  1  clock
io_reset  in  1  asynchronous active-low reset (0 = reset)
io_iBus_cmd_valid  in  1  iBus read request
io_iBus_cmd_ready  out  1  iBus request accepted this cycle
io_iBus_cmd_payload_address  in  ADDR_W  iBus read address
io_iBus_cmd_payload_id  in  ID_W  iBus tag, echoed on response
io_iBus_rsp_valid  out  1  iBus response strobe (no backpressure)
io_iBus_rsp_payload_data  out  DATA_W  read data
io_iBus_rsp_payload_address  out  ADDR_W  echoed request address
io_iBus_rsp_payload_id  out  ID_W  echoed request id
io_dBus_cmd_valid  in  1  dBus request
io_dBus_cmd_ready  out  1  dBus request accepted
io_dBus_cmd_payload_address  in  ADDR_W  address
io_dBus_cmd_payload_data  in  DATA_W  write data
io_dBus_cmd_payload_mask  in  DATA_W/8  byte-enable mask
io_dBus_cmd_payload_write  in  1  1 = write, 0 = read
io_dBus_rsp_valid  out  1  dBus read response strobe
io_dBus_rsp_payload_data  out  DATA_W  read data
io_mem_cmd_valid  out  1  memory request
io_mem_cmd_ready  in  1  memory accepts request
io_mem_cmd_payload_address  out  ADDR_W  address
io_mem_cmd_payload_data  out  DATA_W  write data (0 for iBus)
io_mem_cmd_payload_mask  out  DATA_W/8  byte enables (all ones for iBus)
io_mem_cmd_payload_write  out  1  write flag (0 for iBus)
io_mem_rsp_valid  in  1  memory read response, in issue order
io_mem_rsp_payload_data  in  DATA_W  read data
io_err_spurious  out  1  sticky: a response arrived with no outstanding read

Behaviour:
- Reset (io_reset=0, async):
  - All rsp valids, io_err_spurious and the FIFO count clear to 0.
  - last_grant = DBUS, so iBus wins the first contention.
  - Response payload registers clear to 0.
- Grant (combinational):
  - Only one requester valid: that requester wins.
  - Both valid: the source other than last_grant wins.
  - A requester is "eligible" if it issues a write, or if the FIFO is not full.
  - An ineligible requester never wins; the other requester wins instead if eligible.
- Command path:
  - io_mem_cmd_valid = the winner exists; payload is muxed from the winner.
  - The winner's cmd_ready = io_mem_cmd_ready; the loser's ready = 0.
  - Handshake = winner valid & io_mem_cmd_ready. On handshake, last_grant ← winner.
  - Payload must not change while a winner's valid is held without ready. Grant is not re-evaluated away from a stalled winner (sticky grant until handshake).
- Tag FIFO push, on a read handshake:
  - iBus push: {src=IBUS, address, id}.
  - dBus push: {src=DBUS, 0, 0}.
  - Writes push nothing and never produce a response.
- Full rule: a read is blocked when count == MAX_OUTST, even if a pop occurs in the same cycle. Push and pop in the same cycle when not full leaves count unchanged.
- Response path:
  - On io_mem_rsp_valid with count > 0: pop head, and register one cycle later:
    - head src = IBUS: io_iBus_rsp_valid=1, with data, and the stored address/id.
    - head src = DBUS: io_dBus_rsp_valid=1, with data.
  - Rsp valids are single-cycle pulses.
  - io_mem_rsp_valid with count == 0: response dropped, io_err_spurious ← 1 and held until reset.
- Latency:
  - Command is zero-cycle pass-through.
  - Response is exactly 1 cycle from io_mem_rsp_valid to io_*_rsp_valid.
- FIFO pointers are log2(MAX_OUTST) bits and wrap naturally; count is log2(MAX_OUTST)+1 bits.

Decomposition:
- Package borb_bus_pkg:
  - src_e enum {IBUS, DBUS}.
  - Tag struct {src, address[ADDR_W], id[ID_W]}.
  - Default width localparams.
- Sub-module arb_tag_fifo: synchronous-write FIFO with async active-low reset, push/pop/full/empty/count outputs. It is instantiated once.

Test Plan:
- Basic iBus read:
  - Stimulus: iBus read addr 0x1000, id 5; mem_cmd_ready=1.
  - Response: same cycle, mem_cmd addr 0x1000, write 0, mask 0xFF.
  - Stimulus: mem_rsp data 0xDEAD two cycles later.
  - Response: next cycle, iBus_rsp_valid=1 with data 0xDEAD, addr 0x1000, id 5; dBus_rsp_valid stays 0.
- Round-robin contention:
  - Stimulus: both buses hold valid reads for 4 cycles, mem ready=1, memory responds continuously.
  - Response: grants go I, D, I, D.
  - Stimulus: mem_cmd_ready=0 for 3 cycles mid-stream.
  - Response: winner and payload stay stable; no grant switch.
- Full FIFO:
  - Stimulus: 4 iBus reads accepted with no responses; then an iBus read plus a dBus write, mask 0x0F.
  - Response: iBus ready=0; dBus write is accepted with mask 0x0F on mem_cmd; count stays 4.
- In-order routing:
  - Stimulus: issue I read (id 1), D read, I read (id 2); responses A, B, C.
  - Response: iBus gets A/id 1, then dBus gets B, then iBus gets C/id 2, each 1 cycle after its mem_rsp.
- Spurious response:
  - Stimulus: mem_rsp_valid with FIFO empty.
  - Response: no rsp valids; io_err_spurious=1, held across 10 further idle cycles.
- Reset mid-operation:
  - Stimulus: io_reset=0 asynchronously with 2 reads outstanding and a pending rsp pulse.
  - Response: all outputs 0 immediately; after release, the first mem_rsp is flagged spurious and the next contention grants iBus.
